// File: rtl/seq_gen_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_controller
//  Description : Programmable 3-bit sequence player. A small table of 3-bit
//                entries is loaded while idle, then played back entry by
//                entry, each entry held for div+1 clock cycles. Playback is
//                either one-shot (ending with a done pulse) or looping.
//  Ports       : clk        - sole clock, rising edge
//                reset      - synchronous active-high reset
//                cfg_we     - table write strobe (accepted only when idle)
//                cfg_addr   - table write address
//                cfg_data   - table write data
//                start      - begin playback (level, acted on only when idle)
//                stop       - abort playback (wins over start when idle)
//                loop       - 1: wrap after last entry, 0: one-shot
//                len        - index of the last entry played
//                div        - hold count per entry minus one
//                seq_out    - registered sequence value (0 when idle)
//                seq_valid  - seq_out carries a live playback value
//                busy       - playback in progress
//                done       - one-cycle pulse on one-shot completion
//                cfg_err    - one-cycle pulse when a write is rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_controller #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [2:0]       cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [2:0]       len,
    input  logic [DIV_W-1:0] div,
    output logic [2:0]       seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [2:0]       r_table [DEPTH];
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_cnt_nxt;

    // Playback parameters captured at start; frozen for the whole run
    logic [2:0]       r_len;
    logic [2:0]       w_len_nxt;
    logic             r_loop;
    logic             w_loop_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;

    // Registered outputs
    logic [2:0]       r_seq_out;
    logic [2:0]       w_seq_out_nxt;
    logic             r_seq_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_cfg_err;
    logic             w_cfg_err_nxt;

    logic [2:0]       w_rd_val;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= 3'd0;
            r_div_cnt   <= '0;
            r_len       <= 3'd0;
            r_loop      <= 1'b0;
            r_div       <= '0;
            r_seq_out   <= 3'd0;
            r_seq_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_len       <= w_len_nxt;
            r_loop      <= w_loop_nxt;
            r_div       <= w_div_nxt;
            r_seq_out   <= w_seq_out_nxt;
            r_seq_valid <= (w_state_nxt == c_RUN);
            r_busy      <= (w_state_nxt == c_RUN);
            r_done      <= w_done_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequence table: writable only while idle, cleared by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 3'd0;
            end
        end else if (cfg_we && (r_state == c_IDLE)) begin
            // Addresses beyond DEPTH are silently dropped
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_addr == 3'(i)) begin
                    r_table[i] <= cfg_data;
                end
            end
        end
    end

    // A write attempted during playback is refused and flagged
    assign w_cfg_err_nxt = cfg_we && (r_state == c_RUN);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_div_cnt_nxt = r_div_cnt;
        w_len_nxt     = r_len;
        w_loop_nxt    = r_loop;
        w_div_nxt     = r_div;
        w_done_nxt    = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_idx_nxt     = 3'd0;
                w_div_cnt_nxt = '0;
                if (start && !stop) begin
                    w_state_nxt = c_RUN;
                    w_len_nxt   = len;
                    w_loop_nxt  = loop;
                    w_div_nxt   = div;
                end
            end

            c_RUN: begin
                if (stop) begin
                    // Abort: no done pulse, even on the final cycle
                    w_state_nxt   = c_IDLE;
                    w_idx_nxt     = 3'd0;
                    w_div_cnt_nxt = '0;
                end else if (r_div_cnt == r_div) begin
                    // Current entry has been held div+1 cycles
                    w_div_cnt_nxt = '0;
                    if (r_idx == r_len) begin
                        w_idx_nxt = 3'd0;
                        if (!r_loop) begin
                            w_state_nxt = c_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + c_DIV_ONE;
                end
            end

            default: begin
                w_state_nxt   = c_IDLE;
                w_idx_nxt     = 3'd0;
                w_div_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Table read at the upcoming index; entries beyond DEPTH read as 0
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_idx_nxt == 3'(i)) begin
                w_rd_val = r_table[i];
            end
        end
    end

    // Output value is forced to 0 whenever the block is (or becomes) idle
    assign w_seq_out_nxt = (w_state_nxt == c_RUN) ? w_rd_val : 3'd0;

    assign seq_out   = r_seq_out;
    assign seq_valid = r_seq_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
